// File: rtl/clked_negative_pulse_gen.sv
// Clocked active-low pulse generator.
// A rising edge on trigger starts a low pulse of pulse_len cycles (0 counts as 1).
// A HOLDOFF gap of GAP_CYCLES high cycles follows each pulse.
// Optional feature: define CLKED_NEGATIVE_PULSE_GEN_RETRIGGER_EN so that a start
// request during ACTIVE reloads the length counter instead of being dropped.
module clked_negative_pulse_gen #(
    parameter int LEN_BITS   = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trigger,
    input  logic [LEN_BITS-1:0] pulse_len,
    output logic                pulse_n,
    output logic                busy,
    output logic                done,
    output logic                dropped
);

`ifdef CLKED_NEGATIVE_PULSE_GEN_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    // Gap counter sized for GAP_CYCLES; it keeps one bit even when the gap is disabled.
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                pulse_n_q, pulse_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dropped_q, dropped_d;
    logic                trigger_q, trigger_d;

    logic                start_req;
    logic [LEN_BITS-1:0] len_eff;

    assign start_req = trigger & ~trigger_q;
    assign len_eff   = (pulse_len == '0) ? LEN_BITS'(1) : pulse_len;

    // Next-state and next-output computation for the IDLE/ACTIVE/HOLDOFF sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        pulse_n_d = pulse_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dropped_d = 1'b0;
        trigger_d = trigger;

        case (state_q)
            IDLE: begin
                pulse_n_d = 1'b1;
                busy_d    = 1'b0;
                if (start_req) begin
                    state_d   = ACTIVE;
                    cnt_d     = len_eff;
                    pulse_n_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            ACTIVE: begin
                if (RETRIG && start_req) begin
                    // Reload: the low time restarts from this edge with the new length.
                    cnt_d = len_eff;
                end else begin
                    if (start_req) dropped_d = 1'b1;
                    if (cnt_q <= LEN_BITS'(1)) begin
                        // Last low cycle: release the output and strobe done.
                        cnt_d     = '0;
                        pulse_n_d = 1'b1;
                        done_d    = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_d = HOLDOFF;
                            gap_d   = GAP_LOAD;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - LEN_BITS'(1);
                    end
                end
            end

            HOLDOFF: begin
                if (gap_q <= GW'(1)) begin
                    // Leaving the gap; a request on this very edge starts the next pulse.
                    gap_d = '0;
                    if (start_req) begin
                        state_d   = ACTIVE;
                        cnt_d     = len_eff;
                        pulse_n_d = 1'b0;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_q - GW'(1);
                    if (start_req) dropped_d = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                gap_d     = '0;
                pulse_n_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset wins over everything on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            pulse_n_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            trigger_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            pulse_n_q <= pulse_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
            trigger_q <= trigger_d;
        end
    end

    assign pulse_n = pulse_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_clked_negative_pulse_gen.sv
// Bench for clked_negative_pulse_gen: instance 0 uses GAP_CYCLES=2, instance 1 GAP_CYCLES=0.
// Expected events go into a queue; a monitor turns DUT activity into events and compares.
module tb_clked_negative_pulse_gen;

    localparam logic [1:0] K_PULSE = 2'd0; // val = low length, flag = done seen at release
    localparam logic [1:0] K_BUSY  = 2'd1; // val = busy length
    localparam logic [1:0] K_DROP  = 2'd2;
    localparam logic [1:0] K_BADDN = 2'd3; // done without a rising pulse_n

    typedef struct packed {
        logic [1:0]  kind;
        logic        inst;
        logic [15:0] val;
        logic        flag;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      trig;
    logic [1:0][7:0] len;
    logic            pn0, pn1, bz0, bz1, dn0, dn1, dr0, dr1;
    logic [1:0]      pn, bz, dn, dr;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;

    assign pn = {pn1, pn0};
    assign bz = {bz1, bz0};
    assign dn = {dn1, dn0};
    assign dr = {dr1, dr0};

    always #5 clk = ~clk;

    clked_negative_pulse_gen #(.LEN_BITS(8), .GAP_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(rst), .trigger(trig[0]), .pulse_len(len[0]),
        .pulse_n(pn0), .busy(bz0), .done(dn0), .dropped(dr0)
    );

    clked_negative_pulse_gen #(.LEN_BITS(8), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst), .trigger(trig[1]), .pulse_len(len[1]),
        .pulse_n(pn1), .busy(bz1), .done(dn1), .dropped(dr1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic i, input int v, input logic f);
        ev_t e;
        e.kind = k;
        e.inst = i;
        e.val  = 16'(v);
        e.flag = f;
        exp_q.push_back(e);
    endtask

    task automatic chk(input ev_t o);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d inst=%0d val=%0d flag=%0d, expected none",
                     o.kind, o.inst, o.val, o.flag);
        end else begin
            e = exp_q.pop_front();
            if (e !== o) begin
                n_fail++;
                $display("FAIL event: got kind=%0d inst=%0d val=%0d flag=%0d, expected kind=%0d inst=%0d val=%0d flag=%0d",
                         o.kind, o.inst, o.val, o.flag, e.kind, e.inst, e.val, e.flag);
            end
        end
    endtask

    // One-cycle start request on instance i, sampled at the next rising edge.
    task automatic pulse_trig(input int i, input logic [7:0] l);
        trig[i] = 1'b1;
        len[i]  = l;
        tick();
        trig[i] = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d events still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    // Monitor: converts per-cycle outputs into events, order within a cycle is DROP, PULSE, BUSY.
    initial begin
        int  lowcnt[2];
        int  busycnt[2];
        bit  prev_pn[2];
        bit  prev_bz[2];
        ev_t o;
        for (int i = 0; i < 2; i++) begin
            lowcnt[i] = 0; busycnt[i] = 0; prev_pn[i] = 1'b1; prev_bz[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < 2; i++) begin
                    if (dr[i]) begin
                        o = '{kind: K_DROP, inst: 1'(i), val: 16'd0, flag: 1'b0};
                        chk(o);
                    end
                    if (pn[i] && !prev_pn[i]) begin
                        o = '{kind: K_PULSE, inst: 1'(i), val: 16'(lowcnt[i]), flag: dn[i]};
                        chk(o);
                    end else if (dn[i]) begin
                        o = '{kind: K_BADDN, inst: 1'(i), val: 16'd0, flag: 1'b1};
                        chk(o);
                    end
                    if (!bz[i] && prev_bz[i]) begin
                        o = '{kind: K_BUSY, inst: 1'(i), val: 16'(busycnt[i]), flag: 1'b0};
                        chk(o);
                    end
                    lowcnt[i]  = pn[i] ? 0 : lowcnt[i] + 1;
                    busycnt[i] = bz[i] ? busycnt[i] + 1 : 0;
                    prev_pn[i] = pn[i];
                    prev_bz[i] = bz[i];
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        trig = 2'b00;
        len  = '0;
        repeat (3) tick();

        // Reset state of both instances: pulse_n=1, busy=0, done=0, dropped=0.
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({pn[i], bz[i], dn[i], dr[i]} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_state%0d: got %b, expected 1000", i, {pn[i], bz[i], dn[i], dr[i]});
            end
        end
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) tick();

        // Basic 5-cycle pulse with a 2-cycle gap.
        expect_ev(K_PULSE, 1'b0, 5, 1'b1);
        expect_ev(K_BUSY,  1'b0, 7, 1'b0);
        pulse_trig(0, 8'd5);
        drain("basic", 40);

        // Zero length on the no-gap instance, then a 3-cycle pulse.
        expect_ev(K_PULSE, 1'b1, 1, 1'b1);
        expect_ev(K_BUSY,  1'b1, 1, 1'b0);
        pulse_trig(1, 8'd0);
        drain("zero_len", 20);
        expect_ev(K_PULSE, 1'b1, 3, 1'b1);
        expect_ev(K_BUSY,  1'b1, 3, 1'b0);
        pulse_trig(1, 8'd3);
        drain("nogap3", 20);

        // Trigger held high for 20 cycles gives exactly one pulse.
        expect_ev(K_PULSE, 1'b0, 3, 1'b1);
        expect_ev(K_BUSY,  1'b0, 5, 1'b0);
        trig[0] = 1'b1;
        len[0]  = 8'd3;
        repeat (20) tick();
        trig[0] = 1'b0;
        drain("held", 20);

        // Request one cycle after done lands in HOLDOFF and is dropped.
        expect_ev(K_PULSE, 1'b0, 3, 1'b1);
        expect_ev(K_DROP,  1'b0, 0, 1'b0);
        expect_ev(K_BUSY,  1'b0, 5, 1'b0);
        pulse_trig(0, 8'd3);
        repeat (3) tick();
        pulse_trig(0, 8'd3);
        drain("holdoff_drop", 20);

        // Request on the edge that leaves HOLDOFF starts the next pulse directly.
        expect_ev(K_PULSE, 1'b0, 3, 1'b1);
        expect_ev(K_PULSE, 1'b0, 2, 1'b1);
        expect_ev(K_BUSY,  1'b0, 9, 1'b0);
        pulse_trig(0, 8'd3);
        repeat (4) tick();
        pulse_trig(0, 8'd2);
        drain("idle_edge", 30);

        // Second request two cycles into a 4-cycle pulse, new length 6.
`ifdef CLKED_NEGATIVE_PULSE_GEN_RETRIGGER_EN
        expect_ev(K_PULSE, 1'b0, 8, 1'b1);
        expect_ev(K_BUSY,  1'b0, 10, 1'b0);
`else
        expect_ev(K_DROP,  1'b0, 0, 1'b0);
        expect_ev(K_PULSE, 1'b0, 4, 1'b1);
        expect_ev(K_BUSY,  1'b0, 6, 1'b0);
`endif
        pulse_trig(0, 8'd4);
        tick();
        pulse_trig(0, 8'd6);
        drain("retrigger", 30);

        // Reset on the third low cycle of an 8-cycle pulse: release without done.
        expect_ev(K_PULSE, 1'b0, 3, 1'b0);
        expect_ev(K_BUSY,  1'b0, 3, 1'b0);
        pulse_trig(0, 8'd8);
        tick();
        tick();
        rst     = 1'b1;
        trig[0] = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        trig[0] = 1'b0;
        drain("reset_mid", 20);
        repeat (10) tick();

        // Maximum length 255 without wrap.
        expect_ev(K_PULSE, 1'b0, 255, 1'b1);
        expect_ev(K_BUSY,  1'b0, 257, 1'b0);
        pulse_trig(0, 8'd255);
        drain("max_len", 400);

        repeat (20) tick();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
